// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing a 1-cycle-latency RAM between fetch and data ports
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [31:0]           i_rdata,
   input  logic                  d_req,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [3:0]            d_wstrb,
   input  logic [31:0]           d_wdata,
   input  logic                  d_lock,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [31:0]           d_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [3:0]            mem_write,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   output logic [CNT_WIDTH-1:0]  i_stall_cnt,
   output logic [CNT_WIDTH-1:0]  d_stall_cnt
);

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   logic                 last_gnt_q, last_gnt_d;
   logic                 resp_pending_q, resp_pending_d;
   logic                 resp_owner_q, resp_owner_d;
   logic [CNT_WIDTH-1:0] i_stall_cnt_q, i_stall_cnt_d;
   logic [CNT_WIDTH-1:0] d_stall_cnt_q, d_stall_cnt_d;
   logic                 grant_i, grant_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_gnt_q     <= OWN_D;
         resp_pending_q <= 1'b0;
         resp_owner_q   <= OWN_I;
         i_stall_cnt_q  <= '0;
         d_stall_cnt_q  <= '0;
      end else begin
         last_gnt_q     <= last_gnt_d;
         resp_pending_q <= resp_pending_d;
         resp_owner_q   <= resp_owner_d;
         i_stall_cnt_q  <= i_stall_cnt_d;
         d_stall_cnt_q  <= d_stall_cnt_d;
      end
   end

   // On conflict the lock only holds a grant D already owns; otherwise strict alternation.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (!reset) begin
         if (i_req && d_req) begin
            if (last_gnt_q == OWN_D && !d_lock) grant_i = 1'b1;
            else                                grant_d = 1'b1;
         end else begin
            grant_i = i_req;
            grant_d = d_req;
         end
      end
   end

   always_comb begin
      last_gnt_d     = last_gnt_q;
      resp_owner_d   = resp_owner_q;
      resp_pending_d = grant_i | grant_d;
      if (grant_i) begin
         last_gnt_d   = OWN_I;
         resp_owner_d = OWN_I;
      end else if (grant_d) begin
         last_gnt_d   = OWN_D;
         resp_owner_d = OWN_D;
      end

      i_stall_cnt_d = i_stall_cnt_q;
      if (i_req && !grant_i && !(&i_stall_cnt_q)) i_stall_cnt_d = i_stall_cnt_q + CNT_WIDTH'(1);
      d_stall_cnt_d = d_stall_cnt_q;
      if (d_req && !grant_d && !(&d_stall_cnt_q)) d_stall_cnt_d = d_stall_cnt_q + CNT_WIDTH'(1);
   end

   // Responses are suppressed during reset so an in-flight read is dropped.
   always_comb begin
      i_gnt       = grant_i;
      d_gnt       = grant_d;
      mem_addr    = grant_d ? d_addr : i_addr;
      mem_write   = grant_d ? d_wstrb : 4'b0000;
      mem_wdata   = d_wdata;
      i_rvalid    = resp_pending_q && (resp_owner_q == OWN_I) && !reset;
      d_rvalid    = resp_pending_q && (resp_owner_q == OWN_D) && !reset;
      i_rdata     = mem_rdata;
      d_rdata     = mem_rdata;
      i_stall_cnt = i_stall_cnt_q;
      d_stall_cnt = d_stall_cnt_q;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-master arbiter that shares the single-port synchronous RAM (1-cycle read latency, byte write enables) between the CPU instruction-fetch port and the data port. It sits between the cpu core and the memory array/MMIO bus, and replaces the dedicated combinational fetch port. It arbitrates round-robin, supports a data-side lock for back-to-back accesses, and routes each response to the master that issued the command. Per-master stall counters feed the benchmark counters.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
CNT_WIDTH, 32, width of each saturating stall counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_req  in  1  fetch request, held until i_gnt
i_addr  in  ADDR_WIDTH  fetch byte address (word-aligned)
i_gnt  out  1  fetch command accepted this cycle
i_rvalid  out  1  fetch data valid on i_rdata
i_rdata  out  32  fetch read data
d_req  in  1  data request, held until d_gnt
d_addr  in  ADDR_WIDTH  data byte address
d_wstrb  in  4  byte write enables; 0 means read
d_wdata  in  32  write data
d_lock  in  1  keep the grant on the data port while asserted
d_gnt  out  1  data command accepted this cycle
d_rvalid  out  1  data response (read data or write ack)
d_rdata  out  32  data read data
mem_addr  out  ADDR_WIDTH  memory address
mem_write  out  4  memory byte write enables
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, registered, valid 1 cycle after the address
i_stall_cnt  out  CNT_WIDTH  cycles with i_req=1 and i_gnt=0
d_stall_cnt  out  CNT_WIDTH  cycles with d_req=1 and d_gnt=0

Behaviour:
- Reset (synchronous, active-high): last_gnt=D; resp_pending=0; resp_owner=I; both stall counters=0. In the reset cycle, i_gnt=d_gnt=0 and mem_write=0. A response pending at reset is dropped: no rvalid follows.
- Grant is combinational within a cycle and depends on the inputs and state registers.
  - Only one master requests: grant it.
  - Both request, d_lock=1 and last_gnt=D: grant D.
  - Both request otherwise: grant the master that is not last_gnt (strict alternation).
  - No request: no grant.
- Exactly one of i_gnt and d_gnt is 1 in a cycle, or neither.
- d_lock has no effect when last_gnt=I, so the lock cannot preempt the fetch port.
- Command mux:
  - D granted: mem_addr=d_addr, mem_write=d_wstrb, mem_wdata=d_wdata.
  - I granted or idle: mem_addr=i_addr, mem_write=0, mem_wdata=d_wdata.
  - mem_write is never nonzero unless d_gnt=1.
- On posedge with a grant: last_gnt<=granted master, resp_owner<=granted master, resp_pending<=1. Without a grant: resp_pending<=0 and last_gnt is held.
- Response: i_rvalid=resp_pending&&resp_owner==I; d_rvalid=resp_pending&&resp_owner==D.
  - i_rdata=d_rdata=mem_rdata.
  - Latency is exactly 1 cycle from grant to rvalid, and a write produces a d_rvalid ack.
- Throughput: one command per cycle, fully pipelined. A new grant may coincide with the rvalid of the previous command.
- Masters hold req/addr/wstrb/wdata stable until gnt. Deasserting req before gnt withdraws the request; nothing is issued.
- Stall counters: each increments by 1 per cycle with req=1 and gnt=0, saturates at 2^CNT_WIDTH-1 (no wrap), and is unchanged otherwise. Counting is disabled while reset=1.
- No internal FIFO, and no backpressure on responses: masters must accept rvalid when it is asserted.

Test Plan:
- Fetch only, i_req=1 with i_addr=0x100 for 1 cycle, mem[0x40]=0x00100073 -> i_gnt=1 same cycle, mem_write=0, i_rvalid=1 next cycle with i_rdata=0x00100073, d_rvalid=0 throughout.
- Both requesting continuously from reset -> grants I,D,I,D...; each rvalid goes to the matching owner one cycle later; i_stall_cnt=d_stall_cnt=2 after 4 cycles.
- Both requesting, d_lock=1 after the first D grant for 3 cycles -> grants I,D,D,D,D, then I once d_lock=0; i_stall_cnt increases by 3 during the lock.
- Data write d_addr=0x20004, d_wstrb=4'b0001, d_wdata=0x41 while i_req=1 and last_gnt=I -> mem_write=0001 and mem_addr=0x20004 that cycle; d_rvalid ack next cycle; a byte-lane read-back of 0x41 leaves the other bytes unchanged.
- CNT_WIDTH=4, d_req held with i_req priority forced via lock-free conflict plus d_req deasserted on d_gnt, run 40 cycles -> d_stall_cnt saturates at 15 and does not wrap.
- reset=1 asserted in the cycle after a d_gnt read -> d_rvalid stays 0, counters=0, and the first conflict after reset grants I.
